// File: rtl/clock_face_pkg.sv
// Shared constants, types and helpers for the analog clock-hand overlay.
// Trig values are Q1.FRAC signed; hand indices count 6-degree steps clockwise from 12 o'clock.
package clock_face_pkg;

   localparam int FRAC   = 10;
   localparam int COEF_W = FRAC + 2;
   localparam int DATA_W = 11;
   localparam int ACC_W  = 24;
   localparam int R2_W   = 22;

   localparam logic [23:0] SEC_RGB_DEF  = 24'hff0000;
   localparam logic [23:0] MIN_RGB_DEF  = 24'h00ff00;
   localparam logic [23:0] HOUR_RGB_DEF = 24'h0000ff;
   localparam logic [23:0] HUB_RGB_DEF  = 24'hffffff;

   typedef logic [5:0] hand_idx_t;
   typedef logic signed [COEF_W-1:0] trig_t;

   typedef enum logic [1:0] {
      QUAD_0,
      QUAD_90,
      QUAD_180,
      QUAD_270
   } quad_e;

   // round(sin(k * 6 deg) * 2^FRAC), k = 0..15; valid only for FRAC = 10
   function automatic trig_t quarter_sin(input logic [3:0] k);
      case (k)
         4'd0:    return 12'sd0;
         4'd1:    return 12'sd107;
         4'd2:    return 12'sd213;
         4'd3:    return 12'sd316;
         4'd4:    return 12'sd416;
         4'd5:    return 12'sd512;
         4'd6:    return 12'sd602;
         4'd7:    return 12'sd685;
         4'd8:    return 12'sd761;
         4'd9:    return 12'sd828;
         4'd10:   return 12'sd887;
         4'd11:   return 12'sd935;
         4'd12:   return 12'sd974;
         4'd13:   return 12'sd1002;
         4'd14:   return 12'sd1018;
         default: return 12'sd1024;
      endcase
   endfunction

   // Hour hand creeps one index every 12 minutes.
   function automatic hand_idx_t hour_index(input logic [5:0] hr, input logic [5:0] mn);
      hand_idx_t h12;
      hand_idx_t creep;
      h12   = (hr >= 6'd12) ? hr - 6'd12 : hr;
      creep = mn / 6'd12;
      return h12 * 6'd5 + creep;
   endfunction

endpackage

// File: rtl/hand_trig_lut.sv
// Combinational sin/cos of a hand index, folded from the quarter-wave table.
// Indices 60..63 never get latched; they wrap onto 0..3.
module hand_trig_lut
   import clock_face_pkg::*;
(
   input  hand_idx_t idx,
   output trig_t     sin_v,
   output trig_t     cos_v
);

   hand_idx_t  idx_w;
   quad_e      quad;
   logic [3:0] r;
   trig_t      s_mag;
   trig_t      c_mag;

   always_comb begin
      idx_w = (idx >= 6'd60) ? idx - 6'd60 : idx;
      quad  = QUAD_0;
      r     = 4'(idx_w);
      if (idx_w >= 6'd45) begin
         quad = QUAD_270;
         r    = 4'(idx_w - 6'd45);
      end else if (idx_w >= 6'd30) begin
         quad = QUAD_180;
         r    = 4'(idx_w - 6'd30);
      end else if (idx_w >= 6'd15) begin
         quad = QUAD_90;
         r    = 4'(idx_w - 6'd15);
      end

      s_mag = quarter_sin(r);
      c_mag = quarter_sin(4'd15 - r);

      sin_v = s_mag;
      cos_v = c_mag;
      case (quad)
         QUAD_90: begin
            sin_v = c_mag;
            cos_v = -s_mag;
         end
         QUAD_180: begin
            sin_v = -s_mag;
            cos_v = -c_mag;
         end
         QUAD_270: begin
            sin_v = -c_mag;
            cos_v = s_mag;
         end
         default: begin
            sin_v = s_mag;
            cos_v = c_mag;
         end
      endcase
   end

endmodule

// File: rtl/clock_hand_overlay.sv
// Three-stage per-pixel renderer that composites hour/minute/second hands and a hub
// over a background RGB stream; hand angles are latched at the frame-start pixel.
module clock_hand_overlay
   import clock_face_pkg::*;
#(
   parameter int          CX       = 320,
   parameter int          CY       = 240,
   parameter int          SEC_LEN  = 160,
   parameter int          MIN_LEN  = 130,
   parameter int          HOUR_LEN = 100,
   parameter int          SEC_HW   = 2,
   parameter int          MIN_HW   = 4,
   parameter int          HOUR_HW  = 7,
   parameter int          HUB_R    = 6,
   parameter logic [23:0] SEC_RGB  = SEC_RGB_DEF,
   parameter logic [23:0] MIN_RGB  = MIN_RGB_DEF,
   parameter logic [23:0] HOUR_RGB = HOUR_RGB_DEF,
   parameter logic [23:0] HUB_RGB  = HUB_RGB_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [9:0]  h_addr,
   input  logic [9:0]  v_addr,
   input  logic [23:0] bg_rgb,
   input  logic [5:0]  hour,
   input  logic [5:0]  min,
   input  logic [5:0]  sec,
   input  logic [2:0]  hand_en,
   output logic        out_valid,
   output logic [23:0] out_rgb,
   output logic        time_err
);

   localparam logic signed [DATA_W-1:0] CX_S       = DATA_W'(CX);
   localparam logic signed [DATA_W-1:0] CY_S       = DATA_W'(CY);
   localparam logic signed [ACC_W-1:0]  SEC_LEN_S  = ACC_W'(SEC_LEN);
   localparam logic signed [ACC_W-1:0]  MIN_LEN_S  = ACC_W'(MIN_LEN);
   localparam logic signed [ACC_W-1:0]  HOUR_LEN_S = ACC_W'(HOUR_LEN);
   localparam logic signed [ACC_W-1:0]  SEC_HW_S   = ACC_W'(SEC_HW);
   localparam logic signed [ACC_W-1:0]  MIN_HW_S   = ACC_W'(MIN_HW);
   localparam logic signed [ACC_W-1:0]  HOUR_HW_S  = ACC_W'(HOUR_HW);
   localparam logic signed [R2_W-1:0]   HUB_R2_S   = R2_W'(HUB_R * HUB_R);

   // a*ka +/- b*kb, scaled back to pixels with an arithmetic (floor) shift.
   function automatic logic signed [ACC_W-1:0] rotate(
      input logic signed [DATA_W-1:0] a,
      input trig_t                    ka,
      input logic signed [DATA_W-1:0] b,
      input trig_t                    kb,
      input logic                     diff
   );
      logic signed [ACC_W-1:0] pa;
      logic signed [ACC_W-1:0] pb;
      logic signed [ACC_W-1:0] acc;
      pa  = $signed({{(ACC_W-DATA_W){a[DATA_W-1]}}, a}) *
            $signed({{(ACC_W-COEF_W){ka[COEF_W-1]}}, ka});
      pb  = $signed({{(ACC_W-DATA_W){b[DATA_W-1]}}, b}) *
            $signed({{(ACC_W-COEF_W){kb[COEF_W-1]}}, kb});
      acc = diff ? pa - pb : pa + pb;
      return acc >>> FRAC;
   endfunction

   function automatic logic signed [R2_W-1:0] sq_sum(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [R2_W-1:0] ax;
      logic signed [R2_W-1:0] bx;
      ax = $signed({{(R2_W-DATA_W){a[DATA_W-1]}}, a});
      bx = $signed({{(R2_W-DATA_W){b[DATA_W-1]}}, b});
      return ax * ax + bx * bx;
   endfunction

   function automatic logic signed [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] ? -v : v;
   endfunction

   function automatic logic hand_hit(
      input logic                    en,
      input logic signed [ACC_W-1:0] along,
      input logic signed [ACC_W-1:0] perp,
      input logic signed [ACC_W-1:0] len,
      input logic signed [ACC_W-1:0] hw
   );
      return en && !along[ACC_W-1] && (along < len) && (abs_acc(perp) <= hw);
   endfunction

   hand_idx_t sec_idx;
   hand_idx_t min_idx;
   hand_idx_t hour_idx;
   trig_t     sin_s, cos_s, sin_m, cos_m, sin_h, cos_h;
   logic      frame_start;
   logic      time_ok;

   logic                     vld_p1;
   logic signed [DATA_W-1:0] dx_p1;
   logic signed [DATA_W-1:0] dy_p1;
   logic [23:0]              bg_p1;
   logic [2:0]               en_p1;

   logic                     vld_p2;
   logic signed [ACC_W-1:0]  along_s_p2, perp_s_p2;
   logic signed [ACC_W-1:0]  along_m_p2, perp_m_p2;
   logic signed [ACC_W-1:0]  along_h_p2, perp_h_p2;
   logic signed [R2_W-1:0]   r2_p2;
   logic [23:0]              bg_p2;
   logic [2:0]               en_p2;

   logic        hit_s, hit_m, hit_h, hit_hub;
   logic [23:0] pix_rgb;

   assign frame_start = pix_valid && (h_addr == 10'd0) && (v_addr == 10'd0);
   assign time_ok     = (sec <= 6'd59) && (min <= 6'd59) && (hour <= 6'd23);

   // A bad time sample keeps all three indices so the hands stay mutually consistent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_idx  <= '0;
         min_idx  <= '0;
         hour_idx <= '0;
         time_err <= 1'b0;
      end else if (frame_start) begin
         if (time_ok) begin
            sec_idx  <= sec;
            min_idx  <= min;
            hour_idx <= hour_index(hour, min);
         end else begin
            time_err <= 1'b1;
         end
      end
   end

   hand_trig_lut u_trig_sec  (.idx(sec_idx),  .sin_v(sin_s), .cos_v(cos_s));
   hand_trig_lut u_trig_min  (.idx(min_idx),  .sin_v(sin_m), .cos_v(cos_m));
   hand_trig_lut u_trig_hour (.idx(hour_idx), .sin_v(sin_h), .cos_v(cos_h));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         out_valid <= 1'b0;
         out_rgb   <= '0;
      end else begin
         vld_p1    <= pix_valid;
         vld_p2    <= vld_p1;
         out_valid <= vld_p2;
         if (vld_p2) begin
            out_rgb <= pix_rgb;
         end
      end
   end

   // ---- S1: face-centred coordinates, y pointing up ----
   always_ff @(posedge clk) begin
      dx_p1 <= $signed({1'b0, h_addr}) - CX_S;
      dy_p1 <= CY_S - $signed({1'b0, v_addr});
      bg_p1 <= bg_rgb;
      en_p1 <= hand_en;
   end

   // ---- S2: project onto each hand's axis; trig reflects the index live this cycle ----
   always_ff @(posedge clk) begin
      along_s_p2 <= rotate(dx_p1, sin_s, dy_p1, cos_s, 1'b0);
      perp_s_p2  <= rotate(dx_p1, cos_s, dy_p1, sin_s, 1'b1);
      along_m_p2 <= rotate(dx_p1, sin_m, dy_p1, cos_m, 1'b0);
      perp_m_p2  <= rotate(dx_p1, cos_m, dy_p1, sin_m, 1'b1);
      along_h_p2 <= rotate(dx_p1, sin_h, dy_p1, cos_h, 1'b0);
      perp_h_p2  <= rotate(dx_p1, cos_h, dy_p1, sin_h, 1'b1);
      r2_p2      <= sq_sum(dx_p1, dy_p1);
      bg_p2      <= bg_p1;
      en_p2      <= en_p1;
   end

   // ---- S3: hit tests and priority composite ----
   always_comb begin
      hit_s   = hand_hit(en_p2[0], along_s_p2, perp_s_p2, SEC_LEN_S,  SEC_HW_S);
      hit_m   = hand_hit(en_p2[1], along_m_p2, perp_m_p2, MIN_LEN_S,  MIN_HW_S);
      hit_h   = hand_hit(en_p2[2], along_h_p2, perp_h_p2, HOUR_LEN_S, HOUR_HW_S);
      hit_hub = (r2_p2 <= HUB_R2_S);

      pix_rgb = bg_p2;
      if (hit_hub) begin
         pix_rgb = HUB_RGB;
      end else if (hit_s) begin
         pix_rgb = SEC_RGB;
      end else if (hit_m) begin
         pix_rgb = MIN_RGB;
      end else if (hit_h) begin
         pix_rgb = HOUR_RGB;
      end
   end

endmodule

// File: tb/tb_clock_hand_overlay.sv
// Directed bench for clock_hand_overlay: reset behaviour, hand geometry, priority,
// frame-start angle latching, time error handling and valid/bubble propagation.
module tb_clock_hand_overlay;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic [23:0] bg_rgb;
   logic [5:0]  hour;
   logic [5:0]  min;
   logic [5:0]  sec;
   logic [2:0]  hand_en;
   logic        out_valid;
   logic [23:0] out_rgb;
   logic        time_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clock_hand_overlay dut (
      .clk       (clk),
      .reset     (reset),
      .pix_valid (pix_valid),
      .h_addr    (h_addr),
      .v_addr    (v_addr),
      .bg_rgb    (bg_rgb),
      .hour      (hour),
      .min       (min),
      .sec       (sec),
      .hand_en   (hand_en),
      .out_valid (out_valid),
      .out_rgb   (out_rgb),
      .time_err  (time_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One isolated pixel through an empty pipeline; result appears after the third edge.
   task automatic send_pix(input string tag, input int x, input int y,
                           input logic [23:0] bg, input logic [23:0] exp);
      h_addr    = 10'(x);
      v_addr    = 10'(y);
      bg_rgb    = bg;
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      tick();
      check_bit({tag, "_vld"}, out_valid, 1'b1);
      check_rgb(tag, out_rgb, exp);
   endtask

   task automatic latch_time(input string tag, input int h, input int m, input int s);
      hour      = 6'(h);
      min       = 6'(m);
      sec       = 6'(s);
      h_addr    = 10'd0;
      v_addr    = 10'd0;
      bg_rgb    = 24'h123456;
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      tick();
      check_bit({tag, "_frame_vld"}, out_valid, 1'b1);
   endtask

   logic [11:0] pat;
   logic        exp_v;
   logic [23:0] exp_rgb;

   initial begin
      reset     = 1'b0;
      pix_valid = 1'b0;
      h_addr    = '0;
      v_addr    = '0;
      bg_rgb    = '0;
      hour      = '0;
      min       = '0;
      sec       = '0;
      hand_en   = 3'b111;

      // Reset state
      tick();
      tick();
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_rgb("rst_out_rgb", out_rgb, 24'h000000);
      check_bit("rst_time_err", time_err, 1'b0);

      // Stream valid pixels, then assert reset asynchronously mid-stream
      reset     = 1'b1;
      h_addr    = 10'd320;
      v_addr    = 10'd100;
      bg_rgb    = 24'haaaaaa;
      pix_valid = 1'b1;
      repeat (4) tick();
      check_bit("stream_vld", out_valid, 1'b1);
      check_rgb("stream_rgb_idx0", out_rgb, 24'hff0000);
      reset = 1'b0;
      #1;
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check_rgb("midrst_out_rgb", out_rgb, 24'h000000);
      check_bit("midrst_time_err", time_err, 1'b0);
      tick();
      check_bit("inrst_out_valid", out_valid, 1'b0);
      check_rgb("inrst_out_rgb", out_rgb, 24'h000000);
      pix_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_bit("post_rst_idle", out_valid, 1'b0);

      // First pixel after release: valid exactly three edges later
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      check_bit("lat_c1", out_valid, 1'b0);
      tick();
      check_bit("lat_c2", out_valid, 1'b0);
      tick();
      check_bit("lat_c3", out_valid, 1'b1);
      check_rgb("lat_c3_rgb", out_rgb, 24'hff0000);

      // 00:30:00 -> sec up, min down, hour at index 2
      latch_time("t2", 0, 30, 0);
      send_pix("t2_sec_up",   320, 100, 24'h010203, 24'hff0000);
      send_pix("t2_min_down", 320, 300, 24'h010203, 24'h00ff00);
      send_pix("t2_hub",      320, 240, 24'h010203, 24'hffffff);

      // sec=15 (pointing right), min=hour=0 (up)
      latch_time("t3", 0, 0, 15);
      send_pix("t3_sec_right", 400, 240, 24'h0a0b0c, 24'hff0000);
      send_pix("t3_left_bg",   240, 240, 24'h0a0b0c, 24'h0a0b0c);
      send_pix("t3_min_hour",  320, 160, 24'h0a0b0c, 24'h00ff00);
      send_pix("t3_beyond",    320, 100, 24'h0a0b0c, 24'h0a0b0c);

      // 14:30:45 -> hour index 12 (72 deg)
      latch_time("t4", 14, 30, 45);
      send_pix("t4_hour", 368, 224, 24'h202020, 24'h0000ff);
      hand_en = 3'b011;
      send_pix("t4_hour_off", 368, 224, 24'h202020, 24'h202020);
      hand_en = 3'b111;

      // Mid-frame time change must not move the hands
      latch_time("t5", 0, 0, 0);
      sec = 6'd30;
      send_pix("t5_hold_up",   320, 100, 24'h303030, 24'hff0000);
      send_pix("t5_hold_down", 320, 380, 24'h303030, 24'h303030);
      latch_time("t5b", 0, 0, 30);
      send_pix("t5_new_up",   320, 100, 24'h303030, 24'h303030);
      send_pix("t5_new_down", 320, 380, 24'h303030, 24'hff0000);

      // Invalid time: indices held, sticky error
      latch_time("t6", 0, 0, 61);
      check_bit("t6_err_set", time_err, 1'b1);
      send_pix("t6_kept_down", 320, 380, 24'h404040, 24'hff0000);
      send_pix("t6_kept_up",   320, 100, 24'h404040, 24'h404040);
      latch_time("t6b", 0, 0, 15);
      check_bit("t6_err_sticky", time_err, 1'b1);
      send_pix("t6_new_right", 400, 240, 24'h404040, 24'hff0000);

      // Valid gaps: out_valid follows the input pattern three edges later,
      // out_rgb holds through bubbles
      hand_en = 3'b000;
      h_addr  = 10'd400;
      v_addr  = 10'd240;
      pat     = 12'b1011_0010_1101;
      exp_rgb = 24'hff0000;
      for (int j = 0; j < 14; j++) begin
         pix_valid = (j < 12) ? pat[j] : 1'b0;
         bg_rgb    = {8'(j), 16'hbeef};
         tick();
         exp_v = (j >= 2) ? pat[j-2] : 1'b0;
         if (exp_v) exp_rgb = {8'(j - 2), 16'hbeef};
         check_bit("gap_vld", out_valid, exp_v);
         check_rgb("gap_rgb", out_rgb, exp_rgb);
      end
      pix_valid = 1'b0;
      hand_en   = 3'b111;

      // Only reset clears the error
      reset = 1'b0;
      #1;
      check_bit("final_rst_err", time_err, 1'b0);
      check_rgb("final_rst_rgb", out_rgb, 24'h000000);
      tick();
      reset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
